// File: rtl/junction_sequencer.sv
// junction_sequencer: tick-driven phase controller for a two-road junction.
// Walks AR1->RA1->G1->A1->AR2->RA2->G2->A2 with min/max green hand-over driven
// by latched car requests. Optional pedestrian phase after A2 when the macro
// PED_PHASE_EN is defined; default build has no pedestrian phase.
module junction_sequencer #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_REDAMB    = 1,
  parameter int unsigned T_GREEN_MIN = 3,
  parameter int unsigned T_GREEN_MAX = 5,
  parameter int unsigned T_AMBER     = 1,
  parameter int unsigned T_WALK      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       D1,
  input  logic       D2,
  input  logic       ped_req,
  output logic [5:0] lightseq,
  output logic [3:0] phase,
  output logic       walk
);

  typedef enum logic [3:0] {
    StAr1 = 4'd0,
    StRa1 = 4'd1,
    StG1  = 4'd2,
    StA1  = 4'd3,
    StAr2 = 4'd4,
    StRa2 = 4'd5,
    StG2  = 4'd6,
    StA2  = 4'd7,
    StPed = 4'd8
  } state_e;

  // Limits widened by one bit so cnt+1 never wraps before comparison.
  localparam logic [CNT_W:0] LOne      = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] LAllRed   = (CNT_W+1)'(T_ALLRED);
  localparam logic [CNT_W:0] LRedAmb   = (CNT_W+1)'(T_REDAMB);
  localparam logic [CNT_W:0] LGreenMin = (CNT_W+1)'(T_GREEN_MIN);
  localparam logic [CNT_W:0] LGreenMax = (CNT_W+1)'(T_GREEN_MAX);
  localparam logic [CNT_W:0] LAmber    = (CNT_W+1)'(T_AMBER);
  localparam logic [CNT_W:0] LWalk     = (CNT_W+1)'(T_WALK);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req1;
  logic             r_req2;

  state_e           w_state_d;
  state_e           w_adv;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_done;
  logic             w_unused;
  logic             w_req1_d;
  logic             w_req2_d;

`ifdef PED_PHASE_EN
  logic r_ped;
  logic w_ped_d;
`endif

  assign w_cnt_inc = {1'b0, r_cnt} + LOne;

  // State register, phase counter and request latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StAr1;
      r_cnt   <= '0;
      r_req1  <= 1'b0;
      r_req2  <= 1'b0;
`ifdef PED_PHASE_EN
      r_ped   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_req1  <= w_req1_d;
      r_req2  <= w_req2_d;
`ifdef PED_PHASE_EN
      r_ped   <= w_ped_d;
`endif
    end
  end

  // Next state: phase limit per state, advance on the terminating tick.
  always_comb begin
    w_done   = 1'b0;
    w_adv    = StAr1;
    w_unused = 1'b0;
    case (r_state)
      StAr1: begin w_done = (w_cnt_inc == LAllRed); w_adv = StRa1; end
      StRa1: begin w_done = (w_cnt_inc == LRedAmb); w_adv = StG1;  end
      StG1: begin
        w_done = ((w_cnt_inc >= LGreenMin) && r_req2) || (w_cnt_inc == LGreenMax);
        w_adv  = StA1;
      end
      StA1:  begin w_done = (w_cnt_inc == LAmber);  w_adv = StAr2; end
      StAr2: begin w_done = (w_cnt_inc == LAllRed); w_adv = StRa2; end
      StRa2: begin w_done = (w_cnt_inc == LRedAmb); w_adv = StG2;  end
      StG2: begin
        w_done = ((w_cnt_inc >= LGreenMin) && r_req1) || (w_cnt_inc == LGreenMax);
        w_adv  = StA2;
      end
      StA2: begin
        w_done = (w_cnt_inc == LAmber);
`ifdef PED_PHASE_EN
        w_adv  = r_ped ? StPed : StAr1;
`else
        w_adv  = StAr1;
`endif
      end
`ifdef PED_PHASE_EN
      StPed: begin w_done = (w_cnt_inc == LWalk); w_adv = StAr1; end
`endif
      default: w_unused = 1'b1;
    endcase

    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (w_unused) begin
      // Illegal codes recover to AR1 on the next clock regardless of tick.
      w_state_d = StAr1;
      w_cnt_d   = '0;
    end else if (tick) begin
      if (w_done) begin
        w_state_d = w_adv;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = w_cnt_inc[CNT_W-1:0];
      end
    end

    // Own-road sensor is ignored while green and cleared on green entry.
    w_req1_d = ((w_state_d == StG1) || (r_state == StG1)) ? 1'b0 : (r_req1 | D1);
    w_req2_d = ((w_state_d == StG2) || (r_state == StG2)) ? 1'b0 : (r_req2 | D2);
`ifdef PED_PHASE_EN
    // Clear wins over a press on the PED entry edge.
    w_ped_d  = ((w_state_d == StPed) && (r_state != StPed)) ? 1'b0 : (r_ped | ped_req);
`endif
  end

  // Moore output decode from the state register.
  always_comb begin
    phase = r_state;
    case (r_state)
      StRa1:   lightseq = 6'b110100;
      StG1:    lightseq = 6'b001100;
      StA1:    lightseq = 6'b010100;
      StRa2:   lightseq = 6'b100110;
      StG2:    lightseq = 6'b100001;
      StA2:    lightseq = 6'b100010;
      default: lightseq = 6'b100100;
    endcase
`ifdef PED_PHASE_EN
    walk = (r_state == StPed);
`else
    // No pedestrian phase: the button has no effect.
    walk = 1'b0 & ped_req;
`endif
  end

endmodule

// File: tb/tb_junction_sequencer.sv
// tb_junction_sequencer: directed stimulus with a scoreboard queue. Each step
// pushes the expected phase/walk after its clock edge; a negedge monitor pops
// and compares, and also checks the no-conflicting-greens property every cycle.
module tb_junction_sequencer;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       D1;
  logic       D2;
  logic       ped_req;
  logic [5:0] lightseq;
  logic [3:0] phase;
  logic       walk;

  int n_checks = 0;
  int n_err    = 0;

  logic [4:0] exp_q[$];  // {phase, walk}

  localparam string Rot = "1222223456666670";

  junction_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .D1       (D1),
    .D2       (D2),
    .ped_req  (ped_req),
    .lightseq (lightseq),
    .phase    (phase),
    .walk     (walk)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] lamp(input logic [3:0] p);
    case (p)
      4'd1:    return 6'b110100;
      4'd2:    return 6'b001100;
      4'd3:    return 6'b010100;
      4'd5:    return 6'b100110;
      4'd6:    return 6'b100001;
      4'd7:    return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and safety property.
  always @(negedge clock) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seq", 32'({lightseq, phase, walk}), 32'({lamp(e[4:1]), e[4:1], e[0]}));
    end
    check("safety", 32'((lightseq[3] && lightseq[0]) || (lightseq[3] && !lightseq[2]) ||
                        (lightseq[0] && !lightseq[5])), 32'(0));
  end

  task automatic step(input logic t, input logic d1, input logic d2, input logic p,
                      input logic [3:0] ph);
    logic w;
`ifdef PED_PHASE_EN
    w = (ph == 4'd8);
`else
    w = 1'b0;
`endif
    tick = t; D1 = d1; D2 = d2; ped_req = p;
    @(posedge clock);
    exp_q.push_back({ph, w});
    @(negedge clock);
  endtask

  // Tick every cycle; expected phase per step given as a digit string.
  task automatic run(input string s, input logic d1, input logic d2);
    for (int i = 0; i < s.len(); i++) step(1'b1, d1, d2, 1'b0, 4'(s[i] - 8'h30));
  endtask

  // Tick every 4th cycle.
  task automatic run4(input string s, input logic d2);
    for (int i = 0; i < s.len(); i++)
      step(((i % 4) == 3), 1'b0, d2, 1'b0, 4'(s[i] - 8'h30));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name);
    tick = 1'b0; D1 = 1'b0; D2 = 1'b0; ped_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({name, "_light"}, 32'(lightseq), 32'(6'b100100));
    check({name, "_phase"}, 32'(phase), 32'(0));
    check({name, "_walk"}, 32'(walk), 32'(0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; D1 = 1'b0; D2 = 1'b0; ped_req = 1'b0;
    #1;
    check("reset_light", 32'(lightseq), 32'(6'b100100));
    check("reset_phase", 32'(phase), 32'(0));
    check("reset_walk", 32'(walk), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // Free-running rotation, no requests: two 16-tick rotations.
    run(Rot, 1'b0, 1'b0);
    run(Rot, 1'b0, 1'b0);

    // D2 pulse on G1 tick 1: G1 shortened to 3 ticks; next G1 full length.
    run("12", 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
    run("23456666670", 1'b0, 1'b0);
    run(Rot, 1'b0, 1'b0);

    // D2 held, tick every 4th cycle: G1 occupies 12 clocks.
    run4("00011112222222222223", 1'b1);
    run("456666670", 1'b0, 1'b0);

    // Latch req1 before G2, then reset mid-G2: req1 must be forgotten.
    run("12222234", 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    run("66", 1'b0, 1'b0);
    pulse_reset("rst_mid");
    run(Rot, 1'b0, 1'b0);

    // Both sensors held: each green lasts 3 ticks.
    run("122234566670", 1'b1, 1'b1);
    run("122234566670", 1'b1, 1'b1);
    pulse_reset("rst_both");

    // Pedestrian press in G1, second press on the PED entry edge.
    run("12", 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    run("222345666667", 1'b0, 1'b0);
`ifdef PED_PHASE_EN
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
    run("8880", 1'b0, 1'b0);
`else
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
`endif
    run(Rot, 1'b0, 1'b0);

    #1;
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
